// File: rtl/round_pkg.sv
// Shared definitions for the round sequencer game slice.
// Holds the board and tile-index widths, the controller state encoding and a
// helper that turns a tile index into a one-hot board mask.
package round_pkg;

  localparam int BOARD_W = 8;
  localparam int IDX_W   = 3;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_SHOW  = 3'd2;
  localparam logic [2:0] ST_PLAY  = 3'd3;
  localparam logic [2:0] ST_WIN   = 3'd4;
  localparam logic [2:0] ST_LOSE  = 3'd5;
  localparam logic [2:0] ST_OVER  = 3'd6;

  function automatic logic [BOARD_W-1:0] idx_mask(input logic [IDX_W-1:0] idx);
    logic [BOARD_W-1:0] m;
    m = '0;
    m[idx] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/round_sequencer_timer.sv
// cycle_timer: loadable down-counter used for the SHOW and result phases.
// Ports:
//   clk, reset    clock, synchronous active-low reset (value cleared to 0)
//   load          load load_value this cycle (has priority over counting)
//   load_value    W-bit count to load
//   value         current count
//   done          high while value == 1, i.e. in the last cycle of the phase
// The count stops at 0 and never wraps.
module cycle_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic [W-1:0] value,
  output logic         done
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      value <= '0;
    end else if (load) begin
      value <= load_value;
    end else if (value != '0) begin
      value <= value - W'(1);
    end
  end

  assign done = (value == W'(1));

endmodule

// File: rtl/round_sequencer.sv
// round_sequencer: memory-tile game round controller.
// A target board is fetched from a generator, shown for SHOW_CYCLES, then the
// player picks tiles. Picking every lit tile wins the round, picking an unlit
// tile loses a life. The result is shown for RESULT_CYCLES before the next
// round; running out of lives ends the game until start is pressed again.
// Ports:
//   clk, reset     clock, synchronous active-low reset
//   start          begin/restart a game (honoured in IDLE and OVER only)
//   board_in       8-bit board from the generator
//   board_valid    board_in is usable this cycle
//   guess_valid    one-cycle guess strobe (honoured in PLAY only)
//   guess_idx      tile index being guessed
//   board_req      generator enable, high only while fetching
//   display        tile LEDs
//   score          rounds won, saturating at 255
//   lives          remaining lives
//   round_win      one-cycle pulse on entering the win phase
//   round_lose     one-cycle pulse on entering the lose phase
//   game_over      level, high while the game is over
// All outputs are registered.
module round_sequencer
  import round_pkg::*;
#(
  parameter int SHOW_CYCLES   = 50000000,
  parameter int RESULT_CYCLES = 25000000,
  parameter int MAX_LIVES     = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] board_in,
  input  logic       board_valid,
  input  logic       guess_valid,
  input  logic [2:0] guess_idx,
  output logic       board_req,
  output logic [7:0] display,
  output logic [7:0] score,
  output logic [2:0] lives,
  output logic       round_win,
  output logic       round_lose,
  output logic       game_over
);

  localparam int MAX_CYC = (SHOW_CYCLES > RESULT_CYCLES) ? SHOW_CYCLES : RESULT_CYCLES;
  localparam int TMR_W   = $clog2(MAX_CYC) + 1;

  localparam logic [TMR_W-1:0] SHOW_LOAD   = TMR_W'(SHOW_CYCLES);
  localparam logic [TMR_W-1:0] RESULT_LOAD = TMR_W'(RESULT_CYCLES);
  localparam logic [2:0]       LIVES_INIT  = 3'(MAX_LIVES);

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [2:0] sat_dec(input logic [2:0] v);
    return (v == 3'd0) ? v : v - 3'd1;
  endfunction

  logic [2:0]         state, state_nxt;
  logic [BOARD_W-1:0] target, target_nxt;
  logic [BOARD_W-1:0] picks, picks_nxt;
  logic [BOARD_W-1:0] display_nxt;
  logic [7:0]         score_nxt;
  logic [2:0]         lives_nxt;
  logic               board_req_nxt, win_nxt, lose_nxt, over_nxt;

  logic               tmr_load;
  logic [TMR_W-1:0]   tmr_load_value;
  logic [TMR_W-1:0]   tmr_value;
  logic               tmr_done;

  logic [BOARD_W-1:0] guess_mask;
  logic [BOARD_W-1:0] picks_set;

  cycle_timer #(.W(TMR_W)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (tmr_load),
    .load_value (tmr_load_value),
    .value      (tmr_value),
    .done       (tmr_done)
  );

  assign guess_mask = idx_mask(guess_idx);
  assign picks_set  = picks | guess_mask;

  // Next-state and next-output decode; the registers below hold what the
  // outputs show in the state being entered.
  always_comb begin
    state_nxt      = state;
    target_nxt     = target;
    picks_nxt      = picks;
    display_nxt    = display;
    score_nxt      = score;
    lives_nxt      = lives;
    board_req_nxt  = 1'b0;
    win_nxt        = 1'b0;
    lose_nxt       = 1'b0;
    over_nxt       = 1'b0;
    tmr_load       = 1'b0;
    tmr_load_value = '0;

    case (state)
      ST_IDLE: begin
        display_nxt = '0;
        if (start) begin
          state_nxt     = ST_FETCH;
          score_nxt     = '0;
          lives_nxt     = LIVES_INIT;
          board_req_nxt = 1'b1;
        end
      end

      ST_FETCH: begin
        board_req_nxt = 1'b1;
        display_nxt   = '0;
        // An all-dark board cannot be played, so it is skipped.
        if (board_valid && (board_in != '0)) begin
          state_nxt      = ST_SHOW;
          target_nxt     = board_in;
          picks_nxt      = '0;
          display_nxt    = board_in;
          board_req_nxt  = 1'b0;
          tmr_load       = 1'b1;
          tmr_load_value = SHOW_LOAD;
        end
      end

      ST_SHOW: begin
        display_nxt = target;
        if (tmr_done) begin
          state_nxt   = ST_PLAY;
          display_nxt = picks;
        end
      end

      ST_PLAY: begin
        display_nxt = picks;
        if (guess_valid) begin
          if ((target & guess_mask) == '0) begin
            state_nxt      = ST_LOSE;
            lives_nxt      = sat_dec(lives);
            lose_nxt       = 1'b1;
            display_nxt    = target;
            tmr_load       = 1'b1;
            tmr_load_value = RESULT_LOAD;
          end else if ((picks & guess_mask) == '0) begin
            picks_nxt = picks_set;
            if (picks_set == target) begin
              state_nxt      = ST_WIN;
              score_nxt      = sat_inc(score);
              win_nxt        = 1'b1;
              display_nxt    = target;
              tmr_load       = 1'b1;
              tmr_load_value = RESULT_LOAD;
            end else begin
              display_nxt = picks_set;
            end
          end
          // A repeated correct tile falls through with nothing changed.
        end
      end

      ST_WIN: begin
        display_nxt = target;
        if (tmr_done) begin
          state_nxt     = ST_FETCH;
          board_req_nxt = 1'b1;
          display_nxt   = '0;
        end
      end

      ST_LOSE: begin
        display_nxt = target;
        if (tmr_done) begin
          if (lives == 3'd0) begin
            state_nxt = ST_OVER;
            over_nxt  = 1'b1;
          end else begin
            state_nxt     = ST_FETCH;
            board_req_nxt = 1'b1;
            display_nxt   = '0;
          end
        end
      end

      ST_OVER: begin
        over_nxt    = 1'b1;
        display_nxt = target;
        if (start) begin
          state_nxt     = ST_FETCH;
          score_nxt     = '0;
          lives_nxt     = LIVES_INIT;
          over_nxt      = 1'b0;
          board_req_nxt = 1'b1;
          display_nxt   = '0;
        end
      end

      default: begin
        state_nxt   = ST_IDLE;
        display_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ST_IDLE;
      target     <= '0;
      picks      <= '0;
      display    <= '0;
      score      <= '0;
      lives      <= LIVES_INIT;
      board_req  <= 1'b0;
      round_win  <= 1'b0;
      round_lose <= 1'b0;
      game_over  <= 1'b0;
    end else begin
      state      <= state_nxt;
      target     <= target_nxt;
      picks      <= picks_nxt;
      display    <= display_nxt;
      score      <= score_nxt;
      lives      <= lives_nxt;
      board_req  <= board_req_nxt;
      round_win  <= win_nxt;
      round_lose <= lose_nxt;
      game_over  <= over_nxt;
    end
  end

endmodule
